// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD conversion path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_BIN_W  = 13;
  localparam int SCR_W      = DIGIT_W * NUM_DIGITS;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Latency: purely combinational.
// Backpressure: none.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // A digit >= 5 would become >= 10 after the next shift, so pre-bias it by 3.
  always_comb begin
    dout = din;
    if (din >= bcd_digit_t'(5)) begin
      dout = din + bcd_digit_t'(3);
    end
  end

endmodule

// File: rtl/bcd_converter.sv
// Two-stage pipelined binary-to-BCD converter (shift and add-3), four packed digits out.
// Latency: 2 clocks from sample to output, one conversion per clock.
// Backpressure: none; downstream must accept every result.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [BIN_W-1:0]   binary,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] thousands,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  // Widths above 13 bits could exceed 9999 and would not fit four digits.
  if (BIN_W < 4 || BIN_W > MAX_BIN_W) begin : g_bad_width
    $error("bcd_converter: BIN_W must be within 4..13");
  end

  logic [BIN_W-1:0] bin_r;
  logic             valid_r;
  logic [SCR_W-1:0] result;

  // Stage 1: capture the operand and its valid flag together so they never skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      bin_r   <= binary;
      valid_r <= in_valid;
    end
  end

  // Unrolled double-dabble: one generate block per input bit, MSB first.
  for (genvar it = 0; it < BIN_W; it++) begin : g_iter
    logic [SCR_W-1:0] cur;
    logic [SCR_W-1:0] adj;
    logic [SCR_W-1:0] nxt;
    // The top scratch bit is always zero before a shift since 8191 fits in four digits.
    logic             unused_msb;

    if (it == 0) begin : g_first
      assign cur = '0;
    end else begin : g_chain
      assign cur = g_iter[it-1].nxt;
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
      bcd_add3 u_add3 (
        .din  (cur[d*DIGIT_W +: DIGIT_W]),
        .dout (adj[d*DIGIT_W +: DIGIT_W])
      );
    end

    assign nxt        = {adj[SCR_W-2:0], bin_r[BIN_W-1-it]};
    assign unused_msb = adj[SCR_W-1];
  end

  assign result = g_iter[BIN_W-1].nxt;

  // Stage 2: digits follow every cycle regardless of valid; only out_valid tracks the qualifier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      thousands <= '0;
      hundreds  <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      out_valid <= valid_r;
      thousands <= result[3*DIGIT_W +: DIGIT_W];
      hundreds  <= result[2*DIGIT_W +: DIGIT_W];
      tens      <= result[1*DIGIT_W +: DIGIT_W];
      ones      <= result[0*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: reset, boundaries, full sweep, valid toggling, mid-stream reset.
// Latency: checks outputs two clocks after each driven sample.
// Backpressure: none exercised; the design has no stall path.
module tb_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [12:0] binary;
  logic        out_valid;
  logic [3:0]  thousands;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;

  int total = 0;
  int bad   = 0;

  // Expected pipeline: stage 1 holds what was sampled, stage 2 what should be visible.
  logic        m1_vld;
  logic [15:0] m1_dig;
  logic        m2_vld;
  logic [15:0] m2_dig;
  logic        m2_chk;

  bcd_converter #(.BIN_W(13)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .binary    (binary),
    .out_valid (out_valid),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: digits packed so that 1234 reads as 16'h1234.
  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, wait for the following negedge and compare against the model.
  task automatic step(input string tag, input logic r, input logic v, input int b, input logic [15:0] expd);
    rst_n    = r;
    in_valid = v;
    binary   = 13'(b);
    @(negedge clk);
    if (!r) begin
      m1_vld = 1'b0; m1_dig = 16'h0000;
      m2_vld = 1'b0; m2_dig = 16'h0000; m2_chk = 1'b1;
    end else begin
      m2_vld = m1_vld; m2_dig = m1_dig; m2_chk = m1_vld;
      m1_vld = v;      m1_dig = expd;
    end
    check({tag, "_vld"}, {15'd0, out_valid}, {15'd0, m2_vld});
    if (m2_chk) begin
      check({tag, "_dig"}, {thousands, hundreds, tens, ones}, m2_dig);
    end
  endtask

  initial begin
    int          dir_val [8];
    logic [15:0] dir_exp [8];
    int          tog_val [5];
    logic        tog_vld [5];
    logic [15:0] tog_exp [5];

    m1_vld = 1'b0; m1_dig = '0; m2_vld = 1'b0; m2_dig = '0; m2_chk = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; binary = 13'd1234;

    dir_val = '{0, 8191, 9, 10, 99, 100, 999, 1000};
    dir_exp = '{16'h0000, 16'h8191, 16'h0009, 16'h0010,
                16'h0099, 16'h0100, 16'h0999, 16'h1000};
    tog_val = '{4321, 777, 5005, 60, 8000};
    tog_vld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tog_exp = '{16'h4321, 16'h0777, 16'h5005, 16'h0060, 16'h8000};

    // Reset held for two clocks with a live valid operand on the input.
    step("rst0", 1'b0, 1'b1, 1234, 16'h1234);
    step("rst1", 1'b0, 1'b1, 1234, 16'h1234);

    // Zero, full scale and the decimal carry boundaries, hand-computed.
    for (int k = 0; k < 8; k++) begin
      step("dir", 1'b1, 1'b1, dir_val[k], dir_exp[k]);
    end
    step("flush_a", 1'b1, 1'b0, 0, 16'h0000);
    step("flush_b", 1'b1, 1'b0, 0, 16'h0000);

    // Valid pattern 1,0,1,1,0 must reappear two clocks later.
    for (int k = 0; k < 5; k++) begin
      step("tog", 1'b1, tog_vld[k], tog_val[k], tog_exp[k]);
    end
    step("flush_c", 1'b1, 1'b0, 0, 16'h0000);
    step("flush_d", 1'b1, 1'b0, 0, 16'h0000);

    // Back-to-back sweep with a one-clock reset pulse mid-stream.
    for (int i = 0; i < 8192; i++) begin
      if (i == 4000) begin
        step("mid_rst", 1'b0, 1'b1, i, to_bcd(i));
      end
      step("sweep", 1'b1, 1'b1, i, to_bcd(i));
    end
    step("flush_e", 1'b1, 1'b0, 0, 16'h0000);
    step("flush_f", 1'b1, 1'b0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
